bilinear_fetch: RTL
===================

# bilinear_fetch

Parametrised 2x2 neighbourhood fetch unit for the bilinear scaler. It accepts one source-pixel coordinate per request and clamps it independently on each axis against programmable source width and height. It then reads the four neighbours P00, P01, P10 and P11 through a single synchronous-read memory port and presents them together behind a valid/ready handshake. It sits between the coordinate generator and the interpolation datapath, and replaces four parallel memory instances with one port plus a sequencer.

## Interface
- PIX_W, 8: pixel data width.
- COORD_W, 10: coordinate and dimension width.
- ADDR_W, 16: memory address width.
- MEM_LAT, 1: memory read latency in cycles, range 1..4.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- src_width  in  COORD_W  source image width in pixels; 0 is treated as 1.
- src_height  in  COORD_W  source image height in pixels; 0 is treated as 1.
- base_addr  in  ADDR_W  address of pixel (0,0).
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_x  in  COORD_W  source x coordinate.
- req_y  in  COORD_W  source y coordinate.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  PIX_W  read data, valid MEM_LAT cycles after its address.
- out_valid  out  1  neighbourhood valid.
- out_ready  in  1  downstream ready.
- p00, p01, p10, p11  out  PIX_W each  pixels (x0,y0), (x1,y0), (x0,y1), (x1,y1).
- x_edge, y_edge  out  1 each  set when x1==x0 or y1==y0 respectively.

## Operation
- FSM states: IDLE, CALC, ISSUE, DRAIN, HOLD.
- **IDLE:** req_ready=1. On req_valid, register req_x, req_y, src_width, src_height and base_addr, then go to CALC. Changes to these inputs after acceptance are ignored.
- **CALC:** compute and register the clamped coordinates and the row addresses.
  - Wm = max(W,1)-1 and Hm = max(H,1)-1.
  - x0 = min(x, Wm) and y0 = min(y, Hm).
  - x1 = (x0==Wm) ? x0 : x0+1.
  - y1 = (y0==Hm) ? y0 : y0+1.
  - row0 = base + y0*W and row1 = base + y1*W. Use the product of max(W,1) here.
  - All address arithmetic is modulo 2^ADDR_W.
- **ISSUE:** four cycles with mem_rd=1. mem_addr is row0+x0, row0+x1, row1+x0, row1+x1 in that order, with a 2-bit index counter.
- **Return tracking:**
  - A MEM_LAT-deep tag shift register carries {valid, index} for each read issued.
  - A return is captured into p00, p01, p10 or p11 by index at the end of the cycle in which its tag emerges.
- **DRAIN:** wait until the index-3 return has been captured, then go to HOLD.
- **HOLD:** out_valid=1. Outputs and edge flags stay stable until out_ready; on out_valid&out_ready go to IDLE.
- Duplicate addresses (edges, or 1-pixel images) are still issued as four separate reads.
- **Reset:**
  - Sets state IDLE, req_ready=0 during the reset cycle, out_valid=0, mem_rd=0, mem_addr=0.
  - Clears p00..p11, x_edge, y_edge and the tag pipeline.
  - A reset mid-operation discards any in-flight returns; data arriving after reset is ignored.

## Timing
- Cycle numbering: cycle 0 is the acceptance cycle (req_valid & req_ready).
  - Cycle 1 is CALC.
  - Cycles 2..5 drive the four addresses.
  - Captures happen at the end of cycles 2+MEM_LAT .. 5+MEM_LAT.
  - out_valid first rises in cycle 6+MEM_LAT.
- req_ready is high only in IDLE. No request is accepted while a fetch is outstanding.
- Back-to-back: the cycle after an output handshake is IDLE. Minimum period is 7+MEM_LAT cycles per request.
- out_ready held low keeps HOLD indefinitely. No memory reads occur in HOLD.
- mem_rd is high exactly 4 cycles per request and never outside ISSUE.

## Test plan
- **Interior pixel:** MEM_LAT=1, W=8, H=6, base=0, memory[a]=a[7:0], request (2,3).
  - mem_addr must be 26,27,34,35.
  - p00..p11 must be 26,27,34,35, with both edge flags 0.
  - out_valid must be high in cycle 7.
- **Edges:**
  - Request (7,3) must give addresses 31,31,39,39 with x_edge=1.
  - Request (7,5) must give address 47 four times with x_edge=y_edge=1.
  - Request (20,9) must give the same result as (7,5).
- **Wrap and zero size:**
  - base=0xFFF0, W=8, H=6, request (1,2) must give addresses 0x0001,0x0002,0x0009,0x000A.
  - W=0 must behave as W=1: all x clamp to 0 and x_edge=1.
- **Backpressure:** out_ready low for 5 cycles in HOLD.
  - Outputs must stay stable and req_ready must stay 0.
  - The next request is accepted exactly 1 cycle after the handshake.
- **Latency sweep:** MEM_LAT=3 on the interior case gives the same data, with out_valid first high in cycle 9.
- **Reset mid-operation:** assert rst in cycle 4.
  - Next cycle: out_valid=0, mem_rd=0, req_ready=1.
  - A following request (2,3) must return 26,27,34,35 uncorrupted by stale returns.

Source files
------------

// File: rtl/bilinear_fetch.sv
// Clamped 2x2 neighbourhood fetch: one request -> four sequential reads on a single
// synchronous-read port, presented together as P00/P01/P10/P11 behind valid/ready.
module bilinear_fetch #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] src_width,
  input  logic [COORD_W-1:0] src_height,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   p00,
  output logic [PIX_W-1:0]   p01,
  output logic [PIX_W-1:0]   p10,
  output logic [PIX_W-1:0]   p11,
  output logic               x_edge,
  output logic               y_edge
);

  localparam int PW = 2 * COORD_W;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, HOLD} state_t;

  state_t             state_q;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
  logic [ADDR_W-1:0]  base_q;
  logic [COORD_W-1:0] x0_q, x1_q;
  logic [ADDR_W-1:0]  row0_q, row1_q;
  logic [1:0]         idx_q;
  logic               mem_rd_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               out_valid_q;
  logic [PIX_W-1:0]   p00_q, p01_q, p10_q, p11_q;
  logic               x_edge_q, y_edge_q;
  logic [MEM_LAT-1:0] tag_vld_q;
  logic [1:0]         tag_idx_q [MEM_LAT];

  logic [COORD_W-1:0] w_eff, h_eff, wm, hm;
  logic [COORD_W-1:0] x0_d, y0_d, x1_d, y1_d;
  logic [PW-1:0]      prod0, prod1;
  logic [ADDR_W-1:0]  row0_d, row1_d;
  logic [1:0]         idx_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               ret_vld;
  logic [1:0]         ret_idx;

  // Clamp and row-address arithmetic, consumed only while in CALC.
  always_comb begin
    w_eff  = (w_q == '0) ? COORD_W'(1) : w_q;
    h_eff  = (h_q == '0) ? COORD_W'(1) : h_q;
    wm     = w_eff - COORD_W'(1);
    hm     = h_eff - COORD_W'(1);
    x0_d   = (x_q > wm) ? wm : x_q;
    y0_d   = (y_q > hm) ? hm : y_q;
    x1_d   = (x0_d == wm) ? x0_d : x0_d + COORD_W'(1);
    y1_d   = (y0_d == hm) ? y0_d : y0_d + COORD_W'(1);
    prod0  = PW'(y0_d) * PW'(w_eff);
    prod1  = PW'(y1_d) * PW'(w_eff);
    row0_d = base_q + ADDR_W'(prod0);
    row1_d = base_q + ADDR_W'(prod1);
  end

  // Read order: index bit 1 selects the row, bit 0 the column.
  always_comb begin
    idx_nx  = idx_q + 2'd1;
    addr_nx = (idx_nx[1] ? row1_q : row0_q) + ADDR_W'(idx_nx[0] ? x1_q : x0_q);
  end

  assign ret_vld = tag_vld_q[MEM_LAT-1];
  assign ret_idx = tag_idx_q[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      base_q      <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      idx_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      x_edge_q    <= 1'b0;
      y_edge_q    <= 1'b0;
      tag_vld_q   <= '0;
      for (int k = 0; k < MEM_LAT; k++) tag_idx_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= mem_rd_q;
      tag_idx_q[0] <= idx_q;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end

      if (ret_vld) begin
        case (ret_idx)
          2'd0:    p00_q <= mem_rdata;
          2'd1:    p01_q <= mem_rdata;
          2'd2:    p10_q <= mem_rdata;
          default: p11_q <= mem_rdata;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            x_q     <= req_x;
            y_q     <= req_y;
            w_q     <= src_width;
            h_q     <= src_height;
            base_q  <= base_addr;
            state_q <= CALC;
          end
        end
        CALC: begin
          x0_q       <= x0_d;
          x1_q       <= x1_d;
          row0_q     <= row0_d;
          row1_q     <= row1_d;
          x_edge_q   <= (x1_d == x0_d);
          y_edge_q   <= (y1_d == y0_d);
          idx_q      <= 2'd0;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= row0_d + ADDR_W'(x0_d);
          state_q    <= ISSUE;
        end
        ISSUE: begin
          if (idx_q == 2'd3) begin
            mem_rd_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            idx_q      <= idx_nx;
            mem_addr_q <= addr_nx;
          end
        end
        DRAIN: begin
          if (ret_vld && ret_idx == 2'd3) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign p00       = p00_q;
  assign p01       = p01_q;
  assign p10       = p10_q;
  assign p11       = p11_q;
  assign x_edge    = x_edge_q;
  assign y_edge    = y_edge_q;

  a_rd_only_in_issue: assert property (@(posedge clk) disable iff (rst)
    mem_rd_q |-> (state_q == ISSUE));

endmodule
